// File: rtl/gray_pkg.sv
// Shared definitions for the parametrised Gray counter: direction encoding,
// the flag bundle and width-agnostic binary/Gray conversion helpers.
package gray_pkg;

  localparam int GRAY_MAX_W = 32;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic wrap;
  } gray_flags_t;

  // Narrower codes are passed zero-extended; the conversions are exact for
  // any width up to GRAY_MAX_W because leading zeros map to leading zeros.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/bin2gray_comb.sv
// Purely combinational reflected-binary encoder: gray = bin ^ (bin >> 1).
module bin2gray_comb #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter_param.sv
// WIDTH-bit up/down counter presented in Gray code, with load, sticky
// overflow/underflow flags and a wrap pulse. GRAY_CNT_SATURATE_EN selects saturation.
module gray_counter_param
  import gray_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadBin,
  input  logic             Clr,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] BinOut,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] MAX_B = '1;
  localparam logic [WIDTH-1:0] RST_B = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] b_q, b_d;
  gray_flags_t      flags_q, flags_d;
  logic             step_up, step_dn;
  logic             hit_top, hit_bot;

  // A boundary hit is only an event when an enabled step is actually taken.
  always_comb begin
    step_up = En && !Load && (Dir == DIR_UP);
    step_dn = En && !Load && (Dir == DIR_DOWN);
    hit_top = step_up && (b_q == MAX_B);
    hit_bot = step_dn && (b_q == '0);
  end

  always_comb begin
    b_d          = b_q;
    flags_d.ovf  = flags_q.ovf & ~Clr;
    flags_d.unf  = flags_q.unf & ~Clr;
    flags_d.wrap = 1'b0;

    // The boundary event overrides a simultaneous Clr.
    if (hit_top) flags_d.ovf = 1'b1;
    if (hit_bot) flags_d.unf = 1'b1;

    if (Load) begin
      b_d = LoadBin;
    end else if (step_up) begin
      if (hit_top) begin
`ifdef GRAY_CNT_SATURATE_EN
        b_d = b_q;
`else
        b_d          = '0;
        flags_d.wrap = 1'b1;
`endif
      end else begin
        b_d = b_q + 1'b1;
      end
    end else if (step_dn) begin
      if (hit_bot) begin
`ifdef GRAY_CNT_SATURATE_EN
        b_d = b_q;
`else
        b_d          = MAX_B;
        flags_d.wrap = 1'b1;
`endif
      end else begin
        b_d = b_q - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      b_q     <= RST_B;
      flags_q <= '0;
    end else begin
      b_q     <= b_d;
      flags_q <= flags_d;
    end
  end

  bin2gray_comb #(.WIDTH(WIDTH)) u_enc (
    .bin  (b_q),
    .gray (Output)
  );

  assign BinOut    = b_q;
  assign Overflow  = flags_q.ovf;
  assign Underflow = flags_q.unf;
  assign Wrap      = flags_q.wrap;

`ifdef GRAY_CNT_SATURATE_EN
  a_no_wrap: assert property (@(posedge Clk) !Wrap);
  a_step_gray: assert property (@(posedge Clk) disable iff (Reset)
    $past(En && !Load && !Reset) |-> ($countones(Output ^ $past(Output)) <= 1));
`else
  a_step_gray: assert property (@(posedge Clk) disable iff (Reset)
    $past(En && !Load && !Reset) |-> ($countones(Output ^ $past(Output)) == 1));
`endif

endmodule
